// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling UART receiver for 8 data bits, even parity and 1 stop bit.
// Bytes go downstream over a valid/ready handshake with parity/framing flags and an overrun pulse.
module uart_rx_os16 #(
    parameter int unsigned CLKS_PER_TICK = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic          rx_m;
    logic          rx_s;
    logic [1:0]    sync_fill;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [3:0]    samp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          par_bit;
    logic          armed;
    logic          mid_sample;
    logic          load;

    // Two-flop synchronizer; sync_fill marks when rx_s carries a real line sample
    // rather than its reset value, so the reset 1 cannot arm the receiver.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Free-running 1/16-bit tick divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_comb begin
        tick       = (tick_cnt == TICK_LAST);
        mid_sample = tick && (samp_cnt == 4'd15);
        load       = (state == ST_STOP) && mid_sample;
        busy       = (state != ST_IDLE);
    end

    // Arm start detection once the synchronized line has been seen idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else if ((state == ST_IDLE) && sync_fill[1] && rx_s) begin
            armed <= 1'b1;
        end
    end

    // Frame state machine: start validation at mid-start, then one sample per bit at count 15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            samp_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    samp_cnt <= '0;
                    if (armed && !rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (samp_cnt == 4'd7) begin
                            if (!rx_s) begin
                                samp_cnt <= '0;
                                bit_idx  <= '0;
                                state    <= ST_DATA;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == 4'd15) begin
                            shift_reg <= {rx_s, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
                                state <= ST_PARITY;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == 4'd15) begin
                            par_bit <= rx_s;
                            state   <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == 4'd15) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output slot: load at mid-stop unless still occupied and not being accepted this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (!valid || ready) begin
                    data       <= shift_reg;
                    parity_err <= ^{shift_reg, par_bit};
                    frame_err  <= ~rx_s;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: scoreboard bench for uart_rx_os16 with CLKS_PER_TICK=4 (64 clk per bit).
module tb_uart_rx_os16;

    localparam int unsigned CPT = 4;
    localparam int BITP = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int edge_cnt;
    int ovr_seen = 0;
    int ovr_exp = 0;
    int e_edge;
    int target;
    bit found;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    uart_rx_os16 #(.CLKS_PER_TICK(CPT)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .ready(ready),
        .data(data),
        .valid(valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the tick divider restarts from 0 at the same point.
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: compare each accepted frame against the scoreboard, count overrun cycles.
    always @(negedge clk) begin
        if (rst) begin
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data %02h want no frame", data);
                end else begin
                    e_mon = sb.pop_front();
                    check("data", {24'd0, data}, {24'd0, e_mon.d});
                    check("parity_err", {31'd0, parity_err}, {31'd0, e_mon.pe});
                    check("frame_err", {31'd0, frame_err}, {31'd0, e_mon.fe});
                end
            end
            if (overrun) ovr_seen++;
        end
    end

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; the expectation comes straight from the frame's contents.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                              input int period, input logic expect_out);
        logic [10:0] bits;
        logic        par;
        exp_t        e;
        par  = (^d) ^ bad_par;
        bits = {~bad_stop, par, d, 1'b0};
        e.d  = d;
        e.pe = (par != (^d));
        e.fe = bad_stop;
        if (expect_out) sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            clks(period);
        end
        if (bad_stop) begin
            rx = 1'b0;
            clks(44);
            rx = 1'b1;
            clks(period - 44 + BITP);
        end else begin
            rx = 1'b1;
            clks(period);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic       rbp;
        logic       rbs;
        int         per;

        rst = 1'b0;
        rx = 1'b1;
        ready = 1'b0;
        clks(5);
        check("rst_outputs", {19'd0, valid, parity_err, frame_err, overrun, busy, data}, 32'd0);
        rst = 1'b1;
        clks(BITP);

        ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, BITP, 1'b1);
        clks(8);
        send_frame(8'h01, 1'b1, 1'b0, BITP, 1'b1);
        clks(8);
        send_frame(8'h3C, 1'b0, 1'b1, BITP, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, BITP, 1'b1);
        clks(8);

        // Glitch: 16 clk low must be rejected and busy must drop within 48 clk.
        rx = 1'b0;
        clks(16);
        rx = 1'b1;
        for (int i = 0; i < 48; i++) begin
            if (!busy) break;
            clks(1);
        end
        check("glitch_busy_clear", {31'd0, busy}, 32'd0);
        clks(BITP);
        send_frame(8'h0F, 1'b0, 1'b0, BITP, 1'b1);
        clks(8);

        // Overrun: second frame dropped while the first is held.
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, BITP, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, BITP, 1'b0);
        ovr_exp++;
        clks(2);
        check("ovr_valid_held", {31'd0, valid}, 32'd1);
        check("ovr_data_kept", {24'd0, data}, 32'h11);

        // Simultaneous load and accept: ready high only at the 0x33 load edge.
        fork
            send_frame(8'h33, 1'b0, 1'b0, BITP, 1'b1);
            begin
                found = 1'b0;
                for (int i = 0; i < 200 && !found; i++) begin
                    @(negedge clk);
                    if (busy) begin
                        found  = 1'b1;
                        e_edge = edge_cnt;
                    end
                end
                if (!found) begin
                    checks++;
                    errors++;
                    $display("FAIL start_detect_0x33: got busy 0 want 1 within 200 clk");
                end else begin
                    // START check is the 8th tick after detection, stop sample 160 ticks later;
                    // tick edges fall on multiples of CPT counted from reset release.
                    target = ((e_edge / CPT) + 1) * CPT + 167 * CPT;
                    while (edge_cnt < target - 1) clks(1);
                    ready = 1'b1;
                    clks(1);
                    ready = 1'b0;
                    @(negedge clk);
                    check("simul_data", {24'd0, data}, 32'h33);
                    check("simul_valid", {31'd0, valid}, 32'd1);
                    check("simul_no_overrun", {31'd0, overrun}, 32'd0);
                end
            end
        join
        ready = 1'b1;
        clks(4);

        // Randomized frames with random errors and up to about +/-1.5% baud offset.
        for (int n = 0; n < 12; n++) begin
            rd  = 8'($urandom);
            rbp = ($urandom_range(0, 3) == 0);
            rbs = ($urandom_range(0, 4) == 0);
            per = rbs ? BITP : int'($urandom_range(63, 65));
            send_frame(rd, rbp, rbs, per, 1'b1);
            clks(int'($urandom_range(0, 64)));
        end
        clks(8);

        // Reset in the middle of data bit 4 while the line stays low.
        rx = 1'b0;
        clks(5 * BITP + 16);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i == 4) rst = 1'b1;
            @(negedge clk);
            check("rst_midframe_quiet", {19'd0, valid, parity_err, frame_err, overrun, busy, data}, 32'd0);
            @(posedge clk);
            #1;
        end
        rx = 1'b1;
        clks(2 * BITP);
        send_frame(8'hC3, 1'b0, 1'b0, BITP, 1'b1);
        clks(16);

        check("scoreboard_drained", sb.size(), 32'd0);
        check("overrun_cycles", ovr_seen, ovr_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
